// File: rtl/rw_stage.sv
// Register-write stage: turns memory-stage results into 16-bit half writes, splitting wide results over two cycles.
// Optional build macro RW_R0_DROP_EN: requests targeting register 0 are consumed without writing.
module rw_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mw_valid,
  output logic        mw_ready,
  input  logic [4:0]  mw_rd,
  input  logic        mw_wide,
  input  logic        mw_half,
  input  logic [31:0] mw_result,
  output logic        rw_clken,
  output logic        rw_half,
  output logic [4:0]  rw_rd,
  output logic [15:0] rw_result,
  output logic        rw_busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ONE  = 2'd1,
    LO   = 2'd2
  } state_t;

`ifdef RW_R0_DROP_EN
  localparam bit R0_DROP = 1'b1;
`else
  localparam bit R0_DROP = 1'b0;
`endif

  state_t      state;
  logic [15:0] hi_data;
  logic [4:0]  hi_rd;
  logic        accept;
  logic        drop;

  // Ready depends on state alone, so no combinational loop through an upstream valid.
  assign mw_ready = (state != LO);
  assign accept   = mw_valid && mw_ready;
  assign drop     = R0_DROP && (mw_rd == 5'd0);

  // NOTE: all state below updates with non-blocking assignments so every
  // register samples the same pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      rw_clken  <= 1'b0;
      rw_half   <= 1'b0;
      rw_rd     <= 5'd0;
      rw_result <= 16'd0;
      rw_busy   <= 1'b0;
      hi_data   <= 16'd0;
      hi_rd     <= 5'd0;
    end else if (state == LO) begin
      // Second half of a wide write; the request port is closed this cycle.
      state     <= ONE;
      rw_clken  <= 1'b1;
      rw_half   <= 1'b1;
      rw_rd     <= hi_rd;
      rw_result <= hi_data;
      rw_busy   <= 1'b0;
    end else if (accept && drop) begin
      state    <= IDLE;
      rw_clken <= 1'b0;
    end else if (accept && mw_wide) begin
      state     <= LO;
      rw_clken  <= 1'b1;
      rw_half   <= 1'b0;
      rw_rd     <= mw_rd;
      rw_result <= mw_result[15:0];
      rw_busy   <= 1'b1;
      hi_data   <= mw_result[31:16];
      hi_rd     <= mw_rd;
    end else if (accept) begin
      state     <= ONE;
      rw_clken  <= 1'b1;
      rw_half   <= mw_half;
      rw_rd     <= mw_rd;
      rw_result <= mw_result[15:0];
    end else begin
      // Idle cycle: data outputs keep their last values.
      state    <= IDLE;
      rw_clken <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rw_stage.sv
// Scoreboard bench for rw_stage: the driver queues expected half writes at accept, a monitor pops them on rw_clken.
module tb_rw_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mw_valid;
  logic        mw_ready;
  logic [4:0]  mw_rd;
  logic        mw_wide;
  logic        mw_half;
  logic [31:0] mw_result;
  logic        rw_clken;
  logic        rw_half;
  logic [4:0]  rw_rd;
  logic [15:0] rw_result;
  logic        rw_busy;

  typedef struct packed {
    logic        half;
    logic [4:0]  rd;
    logic [15:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_cmp  = 0;
  int  n_fail = 0;
  int  cyc    = 0;

  rw_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mw_valid  (mw_valid),
    .mw_ready  (mw_ready),
    .mw_rd     (mw_rd),
    .mw_wide   (mw_wide),
    .mw_half   (mw_half),
    .mw_result (mw_result),
    .rw_clken  (rw_clken),
    .rw_half   (rw_half),
    .rw_rd     (rw_rd),
    .rw_result (rw_result),
    .rw_busy   (rw_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every write pulse must match the oldest queued expectation.
  initial begin
    wr_t got;
    wr_t want;
    forever begin
      @(posedge clk);
      #1;
      if (rw_clken === 1'b1) begin
        got = '{half: rw_half, rd: rw_rd, data: rw_result};
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_write: got half=%0d rd=%0d data=%h expected none",
                   got.half, got.rd, got.data);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            n_fail++;
            $display("FAIL write_order: got half=%0d rd=%0d data=%h expected half=%0d rd=%0d data=%h",
                     got.half, got.rd, got.data, want.half, want.rd, want.data);
          end
        end
      end
    end
  end

  // Present a request, wait (bounded) for mw_ready, and queue expected writes at the accepting edge.
  task automatic send(input logic [4:0] rd, input logic wide, input logic half,
                      input logic [31:0] res, output int acc_cyc);
    int waited = 0;
    mw_valid  = 1'b1;
    mw_rd     = rd;
    mw_wide   = wide;
    mw_half   = half;
    mw_result = res;
    acc_cyc   = -1;
    forever begin
      @(negedge clk);
      if (mw_ready === 1'b1) break;
      waited++;
      if (waited > 20) begin
        check("accept_timeout", 32'd1, 32'd0);
        return;
      end
    end
    @(posedge clk);
    acc_cyc = cyc;
`ifdef RW_R0_DROP_EN
    if (rd != 5'd0) begin
`else
    begin
`endif
      if (wide) begin
        exp_q.push_back('{half: 1'b0, rd: rd, data: res[15:0]});
        exp_q.push_back('{half: 1'b1, rd: rd, data: res[31:16]});
      end else begin
        exp_q.push_back('{half: half, rd: rd, data: res[15:0]});
      end
    end
    #2;
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #2;
  endtask

  initial begin
    int c0, c1, c2;
    rst_n     = 1'b0;
    mw_valid  = 1'b0;
    mw_rd     = 5'd0;
    mw_wide   = 1'b0;
    mw_half   = 1'b0;
    mw_result = 32'd0;
    repeat (3) idle_cycle();
    check("rst_clken",  {31'd0, rw_clken}, 32'd0);
    check("rst_half",   {31'd0, rw_half},  32'd0);
    check("rst_rd",     {27'd0, rw_rd},    32'd0);
    check("rst_result", {16'd0, rw_result}, 32'd0);
    check("rst_busy",   {31'd0, rw_busy},  32'd0);
    rst_n = 1'b1;
    idle_cycle();
    check("ready_after_reset", {31'd0, mw_ready}, 32'd1);

    // Narrow write to the high half.
    send(5'd5, 1'b0, 1'b1, 32'h0000_ABCD, c0);
    mw_valid = 1'b0;
    check("narrow_clken", {31'd0, rw_clken}, 32'd1);
    check("narrow_data",  {16'd0, rw_result}, 32'h0000_ABCD);
    idle_cycle();
    check("narrow_clken_off", {31'd0, rw_clken}, 32'd0);
    check("narrow_data_hold", {16'd0, rw_result}, 32'h0000_ABCD);

    // Wide write: low half, then high half.
    send(5'd7, 1'b1, 1'b0, 32'h1234_5678, c0);
    mw_valid = 1'b0;
    check("wide_lo_ready", {31'd0, mw_ready}, 32'd0);
    check("wide_lo_busy",  {31'd0, rw_busy},  32'd1);
    check("wide_lo_data",  {16'd0, rw_result}, 32'h0000_5678);
    idle_cycle();
    check("wide_hi_ready", {31'd0, mw_ready}, 32'd1);
    check("wide_hi_busy",  {31'd0, rw_busy},  32'd0);
    check("wide_hi_half",  {31'd0, rw_half},  32'd1);
    check("wide_hi_data",  {16'd0, rw_result}, 32'h0000_1234);
    idle_cycle();
    check("wide_clken_off", {31'd0, rw_clken}, 32'd0);

    // Streaming narrow writes with mw_valid held high.
    send(5'd1, 1'b0, 1'b0, 32'hFFFF_0101, c0);
    send(5'd2, 1'b0, 1'b1, 32'hEEEE_0202, c1);
    send(5'd3, 1'b0, 1'b0, 32'hDDDD_0303, c2);
    mw_valid = 1'b0;
    check("stream_gap1", c1 - c0, 32'd1);
    check("stream_gap2", c2 - c1, 32'd1);
    repeat (2) idle_cycle();

    // Wide then narrow: the narrow one waits out the LO cycle.
    send(5'd4, 1'b1, 1'b1, 32'hAAAA_BBBB, c0);
    send(5'd9, 1'b0, 1'b0, 32'h7777_CCCC, c1);
    mw_valid = 1'b0;
    check("wide_narrow_spacing", c1 - c0, 32'd2);
    repeat (2) idle_cycle();

    // Reset asserted while the high half is pending.
    send(5'd6, 1'b1, 1'b0, 32'h5555_6666, c0);
    mw_valid = 1'b0;
    rst_n    = 1'b0;
    idle_cycle();
    void'(exp_q.pop_back());
    check("midrst_clken",  {31'd0, rw_clken}, 32'd0);
    check("midrst_result", {16'd0, rw_result}, 32'd0);
    check("midrst_rd",     {27'd0, rw_rd},    32'd0);
    check("midrst_busy",   {31'd0, rw_busy},  32'd0);
    rst_n = 1'b1;
    check("midrst_ready", {31'd0, mw_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      idle_cycle();
      check("post_rst_no_pulse", {31'd0, rw_clken}, 32'd0);
    end

    // Wide write to register 0.
    send(5'd0, 1'b1, 1'b0, 32'h0BAD_F00D, c0);
    mw_valid = 1'b0;
`ifdef RW_R0_DROP_EN
    check("r0_ready", {31'd0, mw_ready}, 32'd1);
    check("r0_clken", {31'd0, rw_clken}, 32'd0);
`else
    check("r0_ready", {31'd0, mw_ready}, 32'd0);
    check("r0_clken", {31'd0, rw_clken}, 32'd1);
`endif
    repeat (3) idle_cycle();

    check("queue_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
